// File: rtl/sha3_pkg.sv
// Shared constants, squeeze FSM encoding and digest geometry helper for the SHA-3 squeeze path.
package sha3_pkg;

  localparam int unsigned STATE_SIZE = 1600;
  localparam int unsigned Z_WIDTH    = 64;
  localparam int unsigned IDX_W      = 5;

  typedef enum logic [1:0] {
    SQ_IDLE      = 2'd0,
    SQ_EMIT      = 2'd1,
    SQ_WAIT_PERM = 2'd2
  } sq_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] dig_words;
    logic [3:0]       last_bytes;
  } digest_geom_t;

  // Word count rounds up; the last word carries 1..8 bytes.
  function automatic digest_geom_t digest_geom(input int unsigned digest_bits);
    digest_geom_t g;
    g.dig_words  = IDX_W'((digest_bits + 32'd63) / 32'd64);
    g.last_bytes = 4'(((digest_bits / 32'd8 - 32'd1) % 32'd8) + 32'd1);
    return g;
  endfunction

endpackage

// File: rtl/sha3_squeeze_unit_if.sv
// Digest word stream from the squeeze unit to its consumer (valid/ready).
interface sha3_squeeze_unit_if;

  logic [0:sha3_pkg::Z_WIDTH-1] OUT_DATA;
  logic                         OUT_VALID;
  logic                         OUT_READY;
  logic                         OUT_LAST;
  logic [3:0]                   OUT_BYTES;

  modport master (
    output OUT_DATA,
    output OUT_VALID,
    input  OUT_READY,
    output OUT_LAST,
    output OUT_BYTES
  );

  modport slave (
    input  OUT_DATA,
    input  OUT_VALID,
    output OUT_READY,
    input  OUT_LAST,
    input  OUT_BYTES
  );

endinterface

// File: rtl/sha3_squeeze_param_chk.sv
// Elaboration-time legality checks on the squeeze unit parameters.
module sha3_squeeze_param_chk #(
  parameter int unsigned R_BLOCK_SIZE = 1152,
  parameter int unsigned DIGEST_BITS  = 224
) ();

  if ((R_BLOCK_SIZE % 64) != 0) begin : g_rate_align
    $error("sha3_squeeze_unit: R_BLOCK_SIZE must be a multiple of 64");
  end

  if ((DIGEST_BITS % 8) != 0) begin : g_digest_align
    $error("sha3_squeeze_unit: DIGEST_BITS must be a multiple of 8");
  end

  if ((DIGEST_BITS < 8) || (DIGEST_BITS > R_BLOCK_SIZE)) begin : g_digest_range
    $error("sha3_squeeze_unit: DIGEST_BITS must lie in 8..R_BLOCK_SIZE");
  end

endmodule

// File: rtl/sha3_word_select.sv
// Combinational extraction of one 64-bit rate word from the Keccak state, with
// the bytes beyond n_bytes_s forced to zero.
module sha3_word_select
  import sha3_pkg::*;
(
  input  logic [0:STATE_SIZE-1] state_s,
  input  logic [IDX_W-1:0]      idx_s,
  input  logic [3:0]            n_bytes_s,
  output logic [0:Z_WIDTH-1]    word_s
);

  localparam logic [0:Z_WIDTH-1] ONES = {Z_WIDTH{1'b1}};

  logic [10:0]          amt_s;
  logic [0:Z_WIDTH-1]   word_raw_s;
  logic [0:Z_WIDTH-1]   mask_s;

  // Bit 0 is the MSB, so word idx is moved down to the low 64 bits by a right shift.
  always_comb begin
    amt_s      = 11'(STATE_SIZE - Z_WIDTH) - {idx_s, 6'b000000};
    word_raw_s = Z_WIDTH'(state_s >> amt_s);
    mask_s     = ONES << (7'd64 - {n_bytes_s, 3'b000});
    word_s     = word_raw_s & mask_s;
  end

endmodule

// File: rtl/sha3_squeeze_unit.sv
// Squeeze stage: captures the final Keccak state and streams the digest as 64-bit words.
// Build option SHA3_SQUEEZE_XOF_EN turns on extendable output with permutation requests.
module sha3_squeeze_unit
  import sha3_pkg::*;
#(
  parameter int unsigned R_BLOCK_SIZE = 1152,
  parameter int unsigned DIGEST_BITS  = 224
) (
  input  logic                  CLK,
  input  logic                  A_RST_N,
  input  logic [0:STATE_SIZE-1] STATE_IN,
  input  logic                  STATE_VALID,
  output logic                  BUSY,
  output logic                  PERM_REQ,
  input  logic                  PERM_DONE,
  input  logic                  STOP,
  sha3_squeeze_unit_if.master   digest
);

  logic stop_s;
  logic perm_done_s;

`ifdef SHA3_SQUEEZE_XOF_EN
  // The stream never ends by itself: wrap at the end of the rate and ask for more state.
  localparam bit               XOF_EN     = 1'b1;
  localparam logic [IDX_W-1:0] END_IDX    = IDX_W'(R_BLOCK_SIZE / 64 - 1);
  localparam logic [3:0]       LAST_BYTES = 4'd8;
  localparam logic             LAST_EN    = 1'b0;

  assign stop_s      = STOP;
  assign perm_done_s = PERM_DONE;
`else
  localparam bit               XOF_EN     = 1'b0;
  localparam digest_geom_t     GEOM       = digest_geom(DIGEST_BITS);
  localparam logic [IDX_W-1:0] END_IDX    = GEOM.dig_words - 5'd1;
  localparam logic [3:0]       LAST_BYTES = GEOM.last_bytes;
  localparam logic             LAST_EN    = 1'b1;

  logic unused_xof_s;
  assign stop_s       = 1'b0;
  assign perm_done_s  = 1'b0;
  assign unused_xof_s = ^{STOP, PERM_DONE};
`endif

  sha3_squeeze_param_chk #(
    .R_BLOCK_SIZE (R_BLOCK_SIZE),
    .DIGEST_BITS  (DIGEST_BITS)
  ) u_param_chk ();

  sq_state_e             fsm_r;
  sq_state_e             fsm_s;
  logic [0:STATE_SIZE-1] state_q_r;
  logic [IDX_W-1:0]      idx_r;
  logic [0:Z_WIDTH-1]    out_data_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic [3:0]            out_bytes_r;
  logic                  perm_req_r;
  logic                  busy_r;

  logic                  xfer_s;
  logic                  capture_s;
  logic                  advance_s;
  logic                  perm_req_s;
  logic                  load_s;
  logic [0:STATE_SIZE-1] sel_state_s;
  logic [IDX_W-1:0]      sel_idx_s;
  logic [3:0]            sel_bytes_s;
  logic                  sel_last_s;
  logic [0:Z_WIDTH-1]    sel_word_s;

  assign xfer_s = out_valid_r & digest.OUT_READY;

  // Next-state logic; STOP outranks both end-of-rate and PERM_DONE.
  always_comb begin
    fsm_s      = fsm_r;
    capture_s  = 1'b0;
    advance_s  = 1'b0;
    perm_req_s = 1'b0;
    case (fsm_r)
      SQ_IDLE: begin
        if (STATE_VALID) begin
          fsm_s     = SQ_EMIT;
          capture_s = 1'b1;
        end else begin
          fsm_s = SQ_IDLE;
        end
      end
      SQ_EMIT: begin
        if (stop_s) begin
          fsm_s = SQ_IDLE;
        end else if (xfer_s && (idx_r == END_IDX)) begin
          if (XOF_EN) begin
            fsm_s      = SQ_WAIT_PERM;
            perm_req_s = 1'b1;
          end else begin
            fsm_s = SQ_IDLE;
          end
        end else if (xfer_s) begin
          advance_s = 1'b1;
        end else begin
          fsm_s = SQ_EMIT;
        end
      end
      SQ_WAIT_PERM: begin
        if (stop_s) begin
          fsm_s = SQ_IDLE;
        end else if (perm_done_s) begin
          fsm_s     = SQ_EMIT;
          capture_s = 1'b1;
        end else begin
          fsm_s = SQ_WAIT_PERM;
        end
      end
      default: begin
        fsm_s = SQ_IDLE;
      end
    endcase
  end

  // The word for the next cycle is selected one step early so the outputs are registers.
  always_comb begin
    load_s      = capture_s | advance_s;
    sel_state_s = capture_s ? STATE_IN : state_q_r;
    sel_idx_s   = capture_s ? {IDX_W{1'b0}} : (idx_r + 5'd1);
    sel_last_s  = LAST_EN & (sel_idx_s == END_IDX);
    sel_bytes_s = (sel_idx_s == END_IDX) ? LAST_BYTES : 4'd8;
  end

  sha3_word_select u_word_select (
    .state_s   (sel_state_s),
    .idx_s     (sel_idx_s),
    .n_bytes_s (sel_bytes_s),
    .word_s    (sel_word_s)
  );

  // FSM, captured state and word index.
  always_ff @(posedge CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      fsm_r     <= SQ_IDLE;
      state_q_r <= {STATE_SIZE{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
    end else begin
      fsm_r <= fsm_s;
      if (capture_s) begin
        state_q_r <= STATE_IN;
      end
      if (load_s) begin
        idx_r <= sel_idx_s;
      end
    end
  end

  // Output registers: a presented word holds until it is taken, then clears on leaving EMIT.
  always_ff @(posedge CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      out_data_r  <= {Z_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_bytes_r <= 4'd0;
      perm_req_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= (fsm_s == SQ_EMIT);
      busy_r      <= (fsm_s != SQ_IDLE);
      perm_req_r  <= perm_req_s;
      if (load_s) begin
        out_data_r  <= sel_word_s;
        out_last_r  <= sel_last_s;
        out_bytes_r <= sel_bytes_s;
      end else if (fsm_s != SQ_EMIT) begin
        out_data_r  <= {Z_WIDTH{1'b0}};
        out_last_r  <= 1'b0;
        out_bytes_r <= 4'd0;
      end
    end
  end

  assign digest.OUT_DATA  = out_data_r;
  assign digest.OUT_VALID = out_valid_r;
  assign digest.OUT_LAST  = out_last_r;
  assign digest.OUT_BYTES = out_bytes_r;
  assign PERM_REQ         = perm_req_r;
  assign BUSY             = busy_r;

endmodule

// File: tb/tb_sha3_squeeze_unit.sv
// Scoreboard bench for sha3_squeeze_unit: stimulus pushes expected words, negedge monitors pop and compare.
module tb_sha3_squeeze_unit;
  import sha3_pkg::*;

  typedef struct {
    logic [0:63] data;
    logic        last;
    logic [3:0]  nbytes;
  } exp_t;

`ifdef SHA3_SQUEEZE_XOF_EN
  localparam int RA = 1088;
`else
  localparam int RA = 1152;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [0:1599]     state_a, state_b;
  logic              sv_a, sv_b, busy_a, busy_b, preq_a, preq_b;
  logic              pdone_a, pdone_b, stop_a, stop_b;

  sha3_squeeze_unit_if bus_a ();
  sha3_squeeze_unit_if bus_b ();

  sha3_squeeze_unit #(.R_BLOCK_SIZE(RA), .DIGEST_BITS(224)) u_dut_a (
    .CLK(clk), .A_RST_N(rst_n), .STATE_IN(state_a), .STATE_VALID(sv_a), .BUSY(busy_a),
    .PERM_REQ(preq_a), .PERM_DONE(pdone_a), .STOP(stop_a), .digest(bus_a));

  sha3_squeeze_unit #(.R_BLOCK_SIZE(576), .DIGEST_BITS(512)) u_dut_b (
    .CLK(clk), .A_RST_N(rst_n), .STATE_IN(state_b), .STATE_VALID(sv_b), .BUSY(busy_b),
    .PERM_REQ(preq_b), .PERM_DONE(pdone_b), .STOP(stop_b), .digest(bus_b));

  always #5 clk = ~clk;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [0:1599] pat_bit(input int sel);
    logic [0:1599] st;
    for (int i = 0; i < 1600; i++) st[i] = (sel == 0) ? i[0] : i[1];
    return st;
  endfunction

  function automatic logic [0:1599] pat_words();
    logic [0:1599] st;
    for (int w = 0; w < 25; w++) st[64*w +: 64] = {8'(w + 1), 8'hA5, 48'h0123_4567_89AB};
    return st;
  endfunction

  function automatic exp_t mk_exp(input logic [0:1599] st, input int w, input int nb, input bit last);
    exp_t e;
    for (int j = 0; j < 64; j++) e.data[j] = (j < 8 * nb) ? st[64*w + j] : 1'b0;
    e.last   = last;
    e.nbytes = 4'(nb);
    return e;
  endfunction

  task automatic push_words(input bit to_b, input logic [0:1599] st, input int nwords,
                            input int last_bytes, input bit with_last);
    exp_t e;
    for (int w = 0; w < nwords; w++) begin
      e = mk_exp(st, w, (with_last && w == nwords - 1) ? last_bytes : 8, with_last && (w == nwords - 1));
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [0:1599] st);
    state_a = st;
    sv_a    = 1'b1;
    tick();
    sv_a    = 1'b0;
  endtask

  task automatic drain(input bit on_b, input int budget);
    int n;
    n = 0;
    while (((on_b ? qb.size() : qa.size()) != 0) && (n < budget)) begin
      tick();
      n++;
    end
    chk(on_b ? "B_drain_pending" : "A_drain_pending", 64'(on_b ? qb.size() : qa.size()), 64'd0);
  endtask

  // Monitors: every accepted word must match the head of its expectation queue.
  always @(negedge clk) begin
    exp_t ea, eb;
    if (bus_a.OUT_VALID === 1'b1 && bus_a.OUT_READY === 1'b1) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL A_unexpected_word: got %h, expected no word", bus_a.OUT_DATA);
      end else begin
        ea = qa.pop_front();
        chk("A_data", 64'(bus_a.OUT_DATA), 64'(ea.data));
        chk("A_last", 64'(bus_a.OUT_LAST), 64'(ea.last));
        chk("A_bytes", 64'(bus_a.OUT_BYTES), 64'(ea.nbytes));
      end
    end
    if (bus_b.OUT_VALID === 1'b1 && bus_b.OUT_READY === 1'b1) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL B_unexpected_word: got %h, expected no word", bus_b.OUT_DATA);
      end else begin
        eb = qb.pop_front();
        chk("B_data", 64'(bus_b.OUT_DATA), 64'(eb.data));
        chk("B_last", 64'(bus_b.OUT_LAST), 64'(eb.last));
        chk("B_bytes", 64'(bus_b.OUT_BYTES), 64'(eb.nbytes));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    state_a = '0; state_b = '0;
    sv_a = 1'b0; sv_b = 1'b0; pdone_a = 1'b0; pdone_b = 1'b0; stop_a = 1'b0; stop_b = 1'b0;
    bus_a.OUT_READY = 1'b0;
    bus_b.OUT_READY = 1'b0;
    #12;
    chk("rst_valid", 64'(bus_a.OUT_VALID), 64'd0);
    chk("rst_data", 64'(bus_a.OUT_DATA), 64'd0);
    chk("rst_bytes", 64'(bus_a.OUT_BYTES), 64'd0);
    chk("rst_last", 64'(bus_a.OUT_LAST), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_perm_req", 64'(preq_a), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifndef SHA3_SQUEEZE_XOF_EN
    // Alternating pattern, full throughput, hand-computed words.
    bus_a.OUT_READY = 1'b1;
    for (int w = 0; w < 3; w++) qa.push_back('{64'h5555_5555_5555_5555, 1'b0, 4'd8});
    qa.push_back('{64'h5555_5555_0000_0000, 1'b1, 4'd4});
    issue_a(pat_bit(0));
    chk("t1_first_valid", 64'(bus_a.OUT_VALID), 64'd1);
    chk("t1_busy", 64'(busy_a), 64'd1);
    tick(); tick(); tick();
    chk("t1_busy_before_last", 64'(busy_a), 64'd1);
    tick();
    chk("t1_valid_after_last", 64'(bus_a.OUT_VALID), 64'd0);
    chk("t1_busy_after_last", 64'(busy_a), 64'd0);
    chk("t1_pending", 64'(qa.size()), 64'd0);

    // Backpressure on word 1 for 5 cycles.
    push_words(1'b0, pat_bit(1), 4, 4, 1'b1);
    issue_a(pat_bit(1));
    tick();
    bus_a.OUT_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_valid", 64'(bus_a.OUT_VALID), 64'd1);
      chk("t2_hold_data", 64'(bus_a.OUT_DATA), 64'h3333_3333_3333_3333);
      tick();
    end
    bus_a.OUT_READY = 1'b1;
    drain(1'b0, 20);

    // STATE_VALID mid-emit and on the last-word transfer are both ignored.
    push_words(1'b0, pat_words(), 4, 4, 1'b1);
    issue_a(pat_words());
    tick();
    state_a = pat_bit(0);
    sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    tick();
    sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    chk("t3_busy_after_last", 64'(busy_a), 64'd0);
    tick(); tick();
    chk("t3_no_restart", 64'(bus_a.OUT_VALID), 64'd0);
    chk("t3_pending", 64'(qa.size()), 64'd0);

    // Asynchronous reset after two transfers, then a clean restart.
    push_words(1'b0, pat_words(), 4, 4, 1'b1);
    issue_a(pat_words());
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_valid", 64'(bus_a.OUT_VALID), 64'd0);
    chk("t4_async_busy", 64'(busy_a), 64'd0);
    chk("t4_async_data", 64'(bus_a.OUT_DATA), 64'd0);
    chk("t4_abandoned", 64'(qa.size()), 64'd2);
    qa.delete();
    tick();
    rst_n = 1'b1;
    tick();
    push_words(1'b0, pat_bit(0), 4, 4, 1'b1);
    issue_a(pat_bit(0));
    drain(1'b0, 20);

    // 576-bit rate, 512-bit digest: eight full words.
    bus_b.OUT_READY = 1'b1;
    push_words(1'b1, pat_words(), 8, 8, 1'b1);
    state_b = pat_words();
    sv_b = 1'b1;
    tick();
    sv_b = 1'b0;
    drain(1'b1, 30);
    tick();
    chk("t5_busy_after_last", 64'(busy_b), 64'd0);
`else
    // 17 words, a single PERM_REQ, then the new state from word 0.
    bus_a.OUT_READY = 1'b1;
    push_words(1'b0, pat_words(), 17, 8, 1'b0);
    issue_a(pat_words());
    for (int k = 0; k < 17; k++) tick();
    chk("x1_perm_req", 64'(preq_a), 64'd1);
    chk("x1_valid_in_wait", 64'(bus_a.OUT_VALID), 64'd0);
    chk("x1_busy_in_wait", 64'(busy_a), 64'd1);
    chk("x1_pending", 64'(qa.size()), 64'd0);
    tick();
    chk("x1_perm_req_pulse", 64'(preq_a), 64'd0);
    tick();
    state_a = pat_bit(0);
    pdone_a = 1'b1;
    tick();
    pdone_a = 1'b0;
    chk("x1_resume_valid", 64'(bus_a.OUT_VALID), 64'd1);
    push_words(1'b0, pat_bit(0), 2, 8, 1'b0);
    tick(); tick();
    bus_a.OUT_READY = 1'b0;
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    chk("x2_stop_valid", 64'(bus_a.OUT_VALID), 64'd0);
    chk("x2_stop_busy", 64'(busy_a), 64'd0);
    chk("x2_pending", 64'(qa.size()), 64'd0);

    // STOP while waiting for the permutation; late PERM_DONE must not restart.
    bus_a.OUT_READY = 1'b1;
    push_words(1'b0, pat_bit(1), 17, 8, 1'b0);
    issue_a(pat_bit(1));
    for (int k = 0; k < 17; k++) tick();
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    chk("x3_stop_busy", 64'(busy_a), 64'd0);
    pdone_a = 1'b1;
    tick();
    pdone_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("x3_idle_valid", 64'(bus_a.OUT_VALID), 64'd0);
      chk("x3_idle_perm_req", 64'(preq_a), 64'd0);
      tick();
    end
    chk("x3_pending", 64'(qa.size()), 64'd0);
`endif

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
